// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store control stage between execute and data memory.
// Accepts one RV32I load/store per handshake, drives a byte-addressed memory
// port with unsigned ops only, sign/zero-extends load data itself and reports
// faults (illegal funct3, out-of-range access, unsplit misalignment).
// Optional feature macro: LSU_MISALIGN_SPLIT_EN -- when defined, misaligned
// H/W accesses are carried out as a sequence of byte accesses instead of faulting.
module lsu_ctrl #(
   parameter int DEPTH = 2048,
   parameter int AW    = 32
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          req_valid,
   output logic          req_ready,
   input  logic          req_we,
   input  logic [2:0]    req_funct3,
   input  logic [AW-1:0] req_addr,
   input  logic [31:0]   req_wdata,
   output logic          mem_en,
   output logic          mem_wr,
   output logic [2:0]    mem_op,
   output logic [AW-1:0] mem_addr,
   output logic [31:0]   mem_wdata,
   input  logic [31:0]   mem_rdata,
   output logic          rsp_valid,
   input  logic          rsp_ready,
   output logic [31:0]   rsp_rdata,
   output logic          rsp_err
);

`ifdef LSU_MISALIGN_SPLIT_EN
   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_ACCESS  = 3'd1,
      ST_WAIT    = 3'd2,
      ST_RESP    = 3'd3,
      ST_S_ISSUE = 3'd4,
      ST_S_CAP   = 3'd5
   } state_t;
`else
   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_ACCESS  = 3'd1,
      ST_WAIT    = 3'd2,
      ST_RESP    = 3'd3
   } state_t;
`endif

   // Range limit widened by one bit so addr+size-1 never wraps.
   localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

   state_t          state_r;
   logic            we_r;
   logic [2:0]      funct3_r;
   logic [AW-1:0]   addr_r;
   logic [31:0]     wdata_r;
   logic [31:0]     rsp_rdata_r;
   logic            rsp_err_r;

   logic [2:0]      size_m1_s;
   logic [AW:0]     end_s;
   logic            illegal_s;
   logic            range_s;
   logic            misalign_s;
   logic [2:0]      op_s;
   logic            acc_s;
   logic            issue_s;
   logic [AW-1:0]   sp_addr_s;
   logic [31:0]     sp_wdata_s;

`ifdef LSU_MISALIGN_SPLIT_EN
   logic [1:0]      idx_r;
   logic [31:0]     buf_r;
   logic [1:0]      last_idx_s;
   logic [7:0]      wbyte_s;
   logic [31:0]     cap_s;
`endif

   // Sign or zero extend a right-justified load value according to funct3.
   function automatic logic [31:0] extend_load(input logic [2:0] f3, input logic [31:0] d);
      logic [31:0] r;
      case (f3)
         3'b000:  r = {{24{d[7]}}, d[7:0]};
         3'b001:  r = {{16{d[15]}}, d[15:0]};
         3'b100:  r = {24'h000000, d[7:0]};
         3'b101:  r = {16'h0000, d[15:0]};
         default: r = d;
      endcase
      return r;
   endfunction

   // Access size minus one for the incoming request (0, 1 or 3 bytes).
   always_comb begin
      size_m1_s = 3'd3;
      case (req_funct3[1:0])
         2'b00:   size_m1_s = 3'd0;
         2'b01:   size_m1_s = 3'd1;
         2'b10:   size_m1_s = 3'd3;
         default: size_m1_s = 3'd3;
      endcase
   end

   // Stores only know B/H/W; loads additionally know BU/HU.
   assign illegal_s  = (req_funct3[1:0] == 2'b11) || (req_funct3 == 3'b110) ||
                       (req_we && req_funct3[2]);
   assign end_s      = {1'b0, req_addr} + {{(AW-2){1'b0}}, size_m1_s};
   assign range_s    = (end_s >= DEPTH_W);
   assign misalign_s = ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00)) ||
                       ((req_funct3[1:0] == 2'b01) && req_addr[0]);

   // Memory op for an aligned access: always the unsigned flavour of the size.
   always_comb begin
      op_s = 3'b100;
      case (funct3_r[1:0])
         2'b00:   op_s = 3'b000;
         2'b01:   op_s = 3'b010;
         default: op_s = 3'b100;
      endcase
   end

`ifdef LSU_MISALIGN_SPLIT_EN
   assign last_idx_s = (funct3_r[1:0] == 2'b01) ? 2'd1 : 2'd3;

   // Pick the store byte for the current split index.
   always_comb begin
      wbyte_s = wdata_r[7:0];
      case (idx_r)
         2'd0:    wbyte_s = wdata_r[7:0];
         2'd1:    wbyte_s = wdata_r[15:8];
         2'd2:    wbyte_s = wdata_r[23:16];
         2'd3:    wbyte_s = wdata_r[31:24];
         default: wbyte_s = wdata_r[7:0];
      endcase
   end

   // Merge the returned byte into the load assembly buffer at the current index.
   always_comb begin
      cap_s = buf_r;
      case (idx_r)
         2'd0:    cap_s[7:0]   = mem_rdata[7:0];
         2'd1:    cap_s[15:8]  = mem_rdata[7:0];
         2'd2:    cap_s[23:16] = mem_rdata[7:0];
         2'd3:    cap_s[31:24] = mem_rdata[7:0];
         default: cap_s = buf_r;
      endcase
   end

   assign issue_s    = (state_r == ST_S_ISSUE);
   assign sp_addr_s  = addr_r + {{(AW-2){1'b0}}, idx_r};
   assign sp_wdata_s = {24'h000000, wbyte_s};
`else
   assign issue_s    = 1'b0;
   assign sp_addr_s  = {AW{1'b0}};
   assign sp_wdata_s = 32'h00000000;
`endif

   // Memory strobes decode straight from the state register so that an
   // asynchronous reset removes them in the same cycle.
   assign acc_s     = (state_r == ST_ACCESS);
   assign mem_en    = acc_s | issue_s;
   assign mem_wr    = mem_en & we_r;
   assign mem_op    = acc_s ? op_s : 3'b000;
   assign mem_addr  = acc_s ? addr_r  : (issue_s ? sp_addr_s  : {AW{1'b0}});
   assign mem_wdata = acc_s ? wdata_r : (issue_s ? sp_wdata_s : 32'h00000000);

   assign req_ready = (state_r == ST_IDLE);
   assign rsp_valid = (state_r == ST_RESP);
   assign rsp_rdata = rsp_rdata_r;
   assign rsp_err   = rsp_err_r;

   // Request sequencing FSM with registered response data/error.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= ST_IDLE;
         we_r        <= 1'b0;
         funct3_r    <= 3'b000;
         addr_r      <= {AW{1'b0}};
         wdata_r     <= 32'h00000000;
         rsp_rdata_r <= 32'h00000000;
         rsp_err_r   <= 1'b0;
`ifdef LSU_MISALIGN_SPLIT_EN
         idx_r       <= 2'd0;
         buf_r       <= 32'h00000000;
`endif
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (req_valid) begin
                  we_r     <= req_we;
                  funct3_r <= req_funct3;
                  addr_r   <= req_addr;
                  wdata_r  <= req_wdata;
                  if (illegal_s || range_s) begin
                     rsp_rdata_r <= 32'h00000000;
                     rsp_err_r   <= 1'b1;
                     state_r     <= ST_RESP;
                  end else if (misalign_s) begin
`ifdef LSU_MISALIGN_SPLIT_EN
                     idx_r   <= 2'd0;
                     buf_r   <= 32'h00000000;
                     state_r <= ST_S_ISSUE;
`else
                     rsp_rdata_r <= 32'h00000000;
                     rsp_err_r   <= 1'b1;
                     state_r     <= ST_RESP;
`endif
                  end else begin
                     state_r <= ST_ACCESS;
                  end
               end
            end
            ST_ACCESS: begin
               if (we_r) begin
                  rsp_rdata_r <= 32'h00000000;
                  rsp_err_r   <= 1'b0;
                  state_r     <= ST_RESP;
               end else begin
                  state_r <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               rsp_rdata_r <= extend_load(funct3_r, mem_rdata);
               rsp_err_r   <= 1'b0;
               state_r     <= ST_RESP;
            end
`ifdef LSU_MISALIGN_SPLIT_EN
            ST_S_ISSUE: begin
               state_r <= ST_S_CAP;
            end
            ST_S_CAP: begin
               if (!we_r) begin
                  buf_r <= cap_s;
               end
               if (idx_r == last_idx_s) begin
                  rsp_rdata_r <= we_r ? 32'h00000000 : extend_load(funct3_r, cap_s);
                  rsp_err_r   <= 1'b0;
                  state_r     <= ST_RESP;
               end else begin
                  idx_r   <= idx_r + 2'd1;
                  state_r <= ST_S_ISSUE;
               end
            end
`endif
            ST_RESP: begin
               if (rsp_ready) begin
                  rsp_rdata_r <= 32'h00000000;
                  rsp_err_r   <= 1'b0;
                  state_r     <= ST_IDLE;
               end
            end
            default: begin
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Self-checking bench for lsu_ctrl. Contains a byte-array stand-in for the
// data memory and a transaction-level reference model (shadow byte array plus
// arithmetic for faults, latency, access count and extension).
// Honours LSU_MISALIGN_SPLIT_EN to select the expected misalignment behaviour.
module tb_lsu_ctrl;

`ifdef LSU_MISALIGN_SPLIT_EN
   localparam bit SPLIT = 1'b1;
`else
   localparam bit SPLIT = 1'b0;
`endif
   localparam int DEPTH = 2048;

   logic        clk;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        mem_en;
   logic        mem_wr;
   logic [2:0]  mem_op;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_err;

   int n_err    = 0;
   int n_checks = 0;
   int en_cnt   = 0;
   logic mem_clear;

   logic [7:0] mem     [0:DEPTH-1];
   logic [7:0] ref_mem [0:DEPTH-1];
   logic [10:0] a0;

   lsu_ctrl #(.DEPTH(DEPTH), .AW(32)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .mem_en(mem_en), .mem_wr(mem_wr), .mem_op(mem_op), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign a0 = mem_addr[10:0];

   // Data memory stand-in: write on strobe, read data one cycle later.
   always @(posedge clk) begin
      if (mem_clear) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= 8'h00;
      end else if (mem_en) begin
         if (mem_wr) begin
            mem[a0] <= mem_wdata[7:0];
            if (mem_op != 3'b000) mem[a0 + 11'd1] <= mem_wdata[15:8];
            if (mem_op == 3'b100) begin
               mem[a0 + 11'd2] <= mem_wdata[23:16];
               mem[a0 + 11'd3] <= mem_wdata[31:24];
            end
         end else begin
            case (mem_op)
               3'b100:  mem_rdata <= {mem[a0 + 11'd3], mem[a0 + 11'd2], mem[a0 + 11'd1], mem[a0]};
               3'b010:  mem_rdata <= {16'h0000, mem[a0 + 11'd1], mem[a0]};
               default: mem_rdata <= {24'h000000, mem[a0]};
            endcase
         end
      end
   end

   // Count memory strobes so each transaction's access count can be checked.
   always @(posedge clk) begin
      if (mem_en) en_cnt <= en_cnt + 1;
   end

   task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Transaction-level reference: fault rules, latency, access count, data.
   task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, output logic e_err, output logic [31:0] e_rd,
                        output int e_lat, output int e_nen);
      int     size;
      bit     legal;
      bit     mis;
      longint last;
      longint v;
      legal = we ? (f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
      size  = 1 << f3[1:0];
      last  = longint'({32'h00000000, addr}) + longint'(size) - 64'sd1;
      mis   = (addr % 32'(size)) != 32'd0;
      e_err = 1'b0;
      e_rd  = 32'h00000000;
      e_lat = 1;
      e_nen = 0;
      if (!legal || last >= longint'(DEPTH)) begin
         e_err = 1'b1;
      end else if (mis && !SPLIT) begin
         e_err = 1'b1;
      end else begin
         e_nen = mis ? size : 1;
         e_lat = mis ? (2 * size + 1) : (we ? 2 : 3);
         if (we) begin
            for (int i = 0; i < size; i++) ref_mem[int'(addr) + i] = wd[8*i +: 8];
         end else begin
            v = 0;
            for (int i = 0; i < size; i++) v = v + (longint'(ref_mem[int'(addr) + i]) << (8 * i));
            if (!f3[2] && size < 4 && v >= (longint'(1) << (8 * size - 1)))
               v = v - (longint'(1) << (8 * size));
            e_rd = v[31:0];
         end
      end
   endtask

   // One full request/response transaction, checked against the model.
   task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input int hold,
                         output logic [31:0] got_rd, output logic got_err);
      logic        e_err;
      logic [31:0] e_rd;
      logic [31:0] held;
      int          e_lat, e_nen, cyc, en0;
      model(we, f3, addr, wd, e_err, e_rd, e_lat, e_nen);
      @(negedge clk);
      chk32("req_ready_idle", {31'd0, req_ready}, 32'd1);
      req_valid  = 1'b1;
      req_we     = we;
      req_funct3 = f3;
      req_addr   = addr;
      req_wdata  = wd;
      rsp_ready  = (hold == 0);
      en0        = en_cnt;
      @(posedge clk);
      #1;
      req_valid  = 1'b0;
      req_addr   = $urandom;
      req_wdata  = $urandom;
      chk32("req_ready_busy", {31'd0, req_ready}, 32'd0);
      cyc = 1;
      while (rsp_valid !== 1'b1 && cyc < 40) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      chk32("latency", 32'(cyc), 32'(e_lat));
      chk32("rsp_rdata", rsp_rdata, e_rd);
      chk32("rsp_err", {31'd0, rsp_err}, {31'd0, e_err});
      chk32("mem_en_count", 32'(en_cnt - en0), 32'(e_nen));
      got_rd  = rsp_rdata;
      got_err = rsp_err;
      held    = rsp_rdata;
      for (int k = 0; k < hold; k++) begin
         @(posedge clk);
         #1;
         chk32("hold_valid", {31'd0, rsp_valid}, 32'd1);
         chk32("hold_rdata", rsp_rdata, held);
         chk32("hold_req_ready", {31'd0, req_ready}, 32'd0);
      end
      if (hold > 0) begin
         @(negedge clk);
         rsp_ready = 1'b1;
      end
      @(posedge clk);
      #1;
      chk32("rsp_drop", {31'd0, rsp_valid}, 32'd0);
      chk32("req_ready_back", {31'd0, req_ready}, 32'd1);
   endtask

   initial begin
      logic [31:0] rd;
      logic        er;
      logic        r_we;
      logic [2:0]  r_f3;
      logic [31:0] r_addr;
      int          r_hold;

      rst_n      = 1'b0;
      mem_clear  = 1'b1;
      req_valid  = 1'b0;
      req_we     = 1'b0;
      req_funct3 = 3'b000;
      req_addr   = 32'h0;
      req_wdata  = 32'h0;
      rsp_ready  = 1'b1;
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = 8'h00;

      repeat (3) @(posedge clk);
      #1;
      chk32("rst_mem_en", {31'd0, mem_en}, 32'd0);
      chk32("rst_mem_wr", {31'd0, mem_wr}, 32'd0);
      chk32("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      chk32("rst_rsp_rdata", rsp_rdata, 32'h0);
      chk32("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
      chk32("rst_mem_addr", mem_addr, 32'h0);
      @(negedge clk);
      rst_n     = 1'b1;
      mem_clear = 1'b0;
      #1;
      chk32("rst_req_ready", {31'd0, req_ready}, 32'd1);

      // 1: word store then load
      do_req(1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 0, rd, er);
      do_req(1'b0, 3'b010, 32'h100, 32'h0, 0, rd, er);
      chk32("t1_lw", rd, 32'hDEADBEEF);

      // 2: byte store, signed and unsigned byte loads
      do_req(1'b1, 3'b000, 32'h20, 32'h12345680, 0, rd, er);
      do_req(1'b0, 3'b000, 32'h20, 32'h0, 0, rd, er);
      chk32("t2_lb", rd, 32'hFFFFFF80);
      do_req(1'b0, 3'b100, 32'h20, 32'h0, 0, rd, er);
      chk32("t2_lbu", rd, 32'h00000080);

      // 3: half store, signed and unsigned half loads
      do_req(1'b1, 3'b001, 32'h40, 32'hABCD8001, 0, rd, er);
      do_req(1'b0, 3'b001, 32'h40, 32'h0, 0, rd, er);
      chk32("t3_lh", rd, 32'hFFFF8001);
      do_req(1'b0, 3'b101, 32'h40, 32'h0, 0, rd, er);
      chk32("t3_lhu", rd, 32'h00008001);

      // 4: misaligned word load over bytes 11,22,33,44
      do_req(1'b1, 3'b000, 32'h101, 32'h11, 0, rd, er);
      do_req(1'b1, 3'b000, 32'h102, 32'h22, 0, rd, er);
      do_req(1'b1, 3'b000, 32'h103, 32'h33, 0, rd, er);
      do_req(1'b1, 3'b000, 32'h104, 32'h44, 0, rd, er);
      do_req(1'b0, 3'b010, 32'h101, 32'h0, 0, rd, er);
`ifdef LSU_MISALIGN_SPLIT_EN
      chk32("t4_lw_split", rd, 32'h44332211);
`else
      chk32("t4_lw_misalign_err", {31'd0, er}, 32'd1);
`endif
      do_req(1'b0, 3'b001, 32'h103, 32'h0, 0, rd, er);
      do_req(1'b1, 3'b001, 32'h105, 32'hBEEF, 0, rd, er);

      // 5: range and funct3 faults, plus the last legal bytes
      do_req(1'b0, 3'b010, 32'h7FE, 32'h0, 0, rd, er);
      chk32("t5_range_err", {31'd0, er}, 32'd1);
      do_req(1'b0, 3'b011, 32'h10, 32'h0, 0, rd, er);
      chk32("t5_f3_err", {31'd0, er}, 32'd1);
      do_req(1'b1, 3'b100, 32'h10, 32'h0, 0, rd, er);
      do_req(1'b1, 3'b010, 32'h7FC, 32'hCAFEF00D, 0, rd, er);
      do_req(1'b0, 3'b010, 32'h7FC, 32'h0, 0, rd, er);
      do_req(1'b1, 3'b000, 32'h7FF, 32'h5A, 0, rd, er);
      do_req(1'b0, 3'b100, 32'h7FF, 32'h0, 0, rd, er);
      do_req(1'b0, 3'b000, 32'h800, 32'h0, 0, rd, er);
      do_req(1'b0, 3'b010, 32'hFFFFFFFE, 32'h0, 0, rd, er);

      // 6a: response held while rsp_ready stays low
      do_req(1'b0, 3'b010, 32'h100, 32'h0, 5, rd, er);

      // 6b: reset in the middle of a store
      @(negedge clk);
      req_valid  = 1'b1;
      req_we     = 1'b1;
      req_funct3 = 3'b010;
`ifdef LSU_MISALIGN_SPLIT_EN
      req_addr   = 32'h201;
`else
      req_addr   = 32'h200;
`endif
      req_wdata  = 32'hA1B2C3D4;
      rsp_ready  = 1'b1;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
`ifdef LSU_MISALIGN_SPLIT_EN
      ref_mem[32'h201] = 8'hD4;
      repeat (2) @(posedge clk);
      #1;
`endif
      chk32("rst_mid_wr_before", {31'd0, mem_wr}, 32'd1);
      #1;
      rst_n = 1'b0;
      #1;
      chk32("rst_mid_wr", {31'd0, mem_wr}, 32'd0);
      chk32("rst_mid_en", {31'd0, mem_en}, 32'd0);
      chk32("rst_mid_valid", {31'd0, rsp_valid}, 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk32("rst_mid_req_ready", {31'd0, req_ready}, 32'd1);
      do_req(1'b0, 3'b010, 32'h200, 32'h0, 0, rd, er);
      do_req(1'b0, 3'b010, 32'h204, 32'h0, 0, rd, er);

      // Randomized traffic against the reference model
      for (int n = 0; n < 80; n++) begin
         r_we   = 1'($urandom_range(0, 1));
         r_f3   = 3'($urandom_range(0, 7));
         r_addr = (n % 3 == 0) ? 32'($urandom_range(2040, 2060)) : 32'($urandom_range(0, 63));
         r_hold = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
         do_req(r_we, r_f3, r_addr, $urandom, r_hold, rd, er);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
